// File: rtl/watch_pkg.sv
// Shared constants and field types for the watch calendar.
package watch_pkg;

    localparam int unsigned HOUR_W  = 5;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned SEC_W   = 6;
    localparam int unsigned MONTH_W = 4;
    localparam int unsigned DAY_W   = 5;
    localparam int unsigned WDAY_W  = 3;

    localparam logic [HOUR_W-1:0] MAX_HOUR = HOUR_W'(23);
    localparam logic [MIN_W-1:0]  MAX_MIN  = MIN_W'(59);
    localparam logic [SEC_W-1:0]  MAX_SEC  = SEC_W'(59);
    localparam logic [WDAY_W-1:0] MAX_WDAY = WDAY_W'(6);

    localparam logic [MONTH_W-1:0] JAN = MONTH_W'(1);
    localparam logic [MONTH_W-1:0] FEB = MONTH_W'(2);
    localparam logic [MONTH_W-1:0] MAR = MONTH_W'(3);
    localparam logic [MONTH_W-1:0] APR = MONTH_W'(4);
    localparam logic [MONTH_W-1:0] MAY = MONTH_W'(5);
    localparam logic [MONTH_W-1:0] JUN = MONTH_W'(6);
    localparam logic [MONTH_W-1:0] JUL = MONTH_W'(7);
    localparam logic [MONTH_W-1:0] AUG = MONTH_W'(8);
    localparam logic [MONTH_W-1:0] SEP = MONTH_W'(9);
    localparam logic [MONTH_W-1:0] OCT = MONTH_W'(10);
    localparam logic [MONTH_W-1:0] NOV = MONTH_W'(11);
    localparam logic [MONTH_W-1:0] DEC = MONTH_W'(12);

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
    } time_t;

    localparam int unsigned TIME_W = $bits(time_t);

endpackage

// File: rtl/watch_month_len.sv
// Days in a month; February honours leap years only when WATCH_LEAP_YEAR_EN is defined.
module watch_month_len
    import watch_pkg::*;
#(
    parameter int unsigned YEAR_W = 12
) (
    input  logic [MONTH_W-1:0] month_i,
    input  logic [YEAR_W-1:0]  year_i,
    output logic [DAY_W-1:0]   len_o
);

    logic leap;

`ifdef WATCH_LEAP_YEAR_EN
    logic [16:0] yr;
    assign yr   = 17'(year_i);
    assign leap = ((yr % 17'd4) == 17'd0) &&
                  (((yr % 17'd100) != 17'd0) || ((yr % 17'd400) == 17'd0));
`else
    logic unused_year;
    assign unused_year = ^year_i;
    assign leap        = 1'b0;
`endif

    // Out-of-range months report zero so any day fails validation.
    always_comb begin
        len_o = '0;
        case (month_i)
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: len_o = DAY_W'(31);
            APR, JUN, SEP, NOV:                len_o = DAY_W'(30);
            FEB:                               len_o = leap ? DAY_W'(29) : DAY_W'(28);
            default:                           len_o = '0;
        endcase
    end

endmodule

// File: rtl/watch_calendar.sv
// Watch time/date counter with prescaler, validated set and rollover pulses.
// Build option: WATCH_LEAP_YEAR_EN enables Gregorian leap-year February.
module watch_calendar
    import watch_pkg::*;
#(
    parameter int unsigned YEAR_W   = 12,
    parameter int unsigned YEAR_MIN = 1,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                set_time,
    input  logic [TIME_W-1:0]   time_in,
    input  logic                set_date,
    input  logic [YEAR_W+8:0]   date_in,
    input  logic [WDAY_W-1:0]   wday_in,
    output logic [YEAR_W-1:0]   year,
    output logic [MONTH_W-1:0]  month,
    output logic [DAY_W-1:0]    day,
    output logic [HOUR_W-1:0]   hour,
    output logic [MIN_W-1:0]    minute,
    output logic [SEC_W-1:0]    second,
    output logic [WDAY_W-1:0]   wday,
    output logic                tick_sec,
    output logic                day_roll,
    output logic                set_err
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [YEAR_W-1:0]  YEAR_RST   = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0]  YEAR_TOP   = '1;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [YEAR_W-1:0]  year_q, year_d;
    logic [MONTH_W-1:0] month_q, month_d;
    logic [DAY_W-1:0]   day_q, day_d;
    logic [HOUR_W-1:0]  hour_q, hour_d;
    logic [MIN_W-1:0]   min_q, min_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic [WDAY_W-1:0]  wday_q, wday_d;
    logic               tick_q, tick_d;
    logic               roll_q, roll_d;
    logic               err_q, err_d;

    time_t              t_in;
    logic [YEAR_W-1:0]  d_year;
    logic [MONTH_W-1:0] d_month;
    logic [DAY_W-1:0]   d_day;
    logic [DAY_W-1:0]   cur_len, set_len;
    logic               tick_c, day_carry_c, time_ok_c, date_ok_c;

    assign t_in    = time_t'(time_in);
    assign d_year  = date_in[YEAR_W+8:9];
    assign d_month = date_in[8:5];
    assign d_day   = date_in[4:0];

    watch_month_len #(.YEAR_W(YEAR_W)) u_len_cnt (
        .month_i (month_q),
        .year_i  (year_q),
        .len_o   (cur_len)
    );

    watch_month_len #(.YEAR_W(YEAR_W)) u_len_set (
        .month_i (d_month),
        .year_i  (d_year),
        .len_o   (set_len)
    );

    assign time_ok_c = (t_in.hour <= MAX_HOUR) && (t_in.minute <= MAX_MIN) &&
                       (t_in.second <= MAX_SEC);
    assign date_ok_c = (d_month >= JAN) && (d_month <= DEC) && (d_day != '0) &&
                       (d_day <= set_len) && (d_year >= YEAR_RST) && (wday_in <= MAX_WDAY);

    // A set_time restarts the second, so a coincident tick is dropped.
    assign tick_c = en && (presc_q == PRESC_LAST) && !set_time;

    always_comb begin
        presc_d     = presc_q;
        year_d      = year_q;
        month_d     = month_q;
        day_d       = day_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        wday_d      = wday_q;
        day_carry_c = 1'b0;

        if (set_time) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
        end

        if (tick_c) begin
            if (sec_q == MAX_SEC) begin
                sec_d = '0;
                if (min_q == MAX_MIN) begin
                    min_d = '0;
                    if (hour_q == MAX_HOUR) begin
                        hour_d      = '0;
                        day_carry_c = 1'b1;
                    end else begin
                        hour_d = hour_q + HOUR_W'(1);
                    end
                end else begin
                    min_d = min_q + MIN_W'(1);
                end
            end else begin
                sec_d = sec_q + SEC_W'(1);
            end
        end

        // Date load takes priority over the day carry from the same tick.
        if (set_date && date_ok_c) begin
            year_d  = d_year;
            month_d = d_month;
            day_d   = d_day;
            wday_d  = wday_in;
        end else if (day_carry_c) begin
            wday_d = (wday_q == MAX_WDAY) ? '0 : wday_q + WDAY_W'(1);
            if (day_q == cur_len) begin
                day_d = DAY_W'(1);
                if (month_q == DEC) begin
                    month_d = JAN;
                    year_d  = (year_q == YEAR_TOP) ? YEAR_RST : year_q + YEAR_W'(1);
                end else begin
                    month_d = month_q + MONTH_W'(1);
                end
            end else begin
                day_d = day_q + DAY_W'(1);
            end
        end

        if (set_time && time_ok_c) begin
            hour_d = t_in.hour;
            min_d  = t_in.minute;
            sec_d  = t_in.second;
        end

        tick_d = tick_c;
        roll_d = day_carry_c && !(set_date && date_ok_c);
        err_d  = (set_time && !time_ok_c) || (set_date && !date_ok_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            year_q  <= YEAR_RST;
            month_q <= JAN;
            day_q   <= DAY_W'(1);
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            wday_q  <= '0;
            tick_q  <= 1'b0;
            roll_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            year_q  <= year_d;
            month_q <= month_d;
            day_q   <= day_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            wday_q  <= wday_d;
            tick_q  <= tick_d;
            roll_q  <= roll_d;
            err_q   <= err_d;
        end
    end

    assign year     = year_q;
    assign month    = month_q;
    assign day      = day_q;
    assign hour     = hour_q;
    assign minute   = min_q;
    assign second   = sec_q;
    assign wday     = wday_q;
    assign tick_sec = tick_q;
    assign day_roll = roll_q;
    assign set_err  = err_q;

endmodule

// File: doc/watch_calendar.md
WATCH_CALENDAR -- requirements
Module: watch_calendar

Interface
REQ-001 Parameter: YEAR_W, 12, year field width in bits; legal range 8..16.
REQ-002 Parameter: YEAR_MIN, 1, year value loaded at reset and after year wrap.
REQ-003 Parameter: TICK_DIV, 1, enabled clk cycles per second; legal range 1..2^26.
REQ-004 Port: clk  in  1  clock, all state on rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-low.
REQ-006 Port: en  in  1  count enable; prescaler advances only while high.
REQ-007 Port: set_time  in  1  load time_in this cycle.
REQ-008 Port: time_in  in  17  {hour[4:0], minute[5:0], second[5:0]}.
REQ-009 Port: set_date  in  1  load date_in and wday_in this cycle.
REQ-010 Port: date_in  in  YEAR_W+9  {year, month[3:0], day[4:0]}.
REQ-011 Port: wday_in  in  3  day of week, 0..6.
REQ-012 Ports: year out YEAR_W; month out 4; day out 5; hour out 5; minute out 6; second out 6; wday out 3; all registered.
REQ-013 Ports: tick_sec, day_roll, set_err  out  1 each; single-cycle registered pulses.

Function
REQ-014 Prescaler shall count 0..TICK_DIV-1 on enabled cycles, hold when en=0, and issue one internal tick at terminal count.
REQ-015 On tick, second shall increment; 59->0 carries to minute; minute 59->0 carries to hour; hour 23->0 carries to day; all updated on the same edge as tick.
REQ-016 Day carry: day==month length -> day=1, month+1; month 12 -> month=1, year+1; every day carry shall set wday=(wday+1) mod 7 and pulse day_roll.
REQ-017 Year wrap: year==2^YEAR_W-1 with year carry -> year=YEAR_MIN.
REQ-018 Month length: 31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; February per REQ-027/028.
REQ-019 tick_sec shall pulse on the edge the second register advances.
REQ-020 Set validation: hour<=23, minute<=59, second<=59; month 1..12, day 1..length(month,year), year>=YEAR_MIN, wday_in<=6.
REQ-021 Valid set loads fields at next edge; invalid set leaves all fields unchanged and pulses set_err next cycle.
REQ-022 set_time (valid or not) shall clear the prescaler; tick in the same cycle is discarded.
REQ-023 set_date and set_time together: each validated independently; date validation uses date_in; either failing pulses set_err; the valid one loads.
REQ-024 set_date with a same-cycle tick: date load wins for date fields and wday; time fields still advance, but the day carry is dropped.

Reset
REQ-025 rst low shall asynchronously force year=YEAR_MIN, month=1, day=1, hour=minute=second=0, wday=0, prescaler=0, all pulses 0.
REQ-026 Reset mid-count discards partial prescaler progress; counting resumes from 0 on the first enabled cycle after release.

Configuration
REQ-027 With WATCH_LEAP_YEAR_EN defined: February length 29 when year%4==0 and (year%100!=0 or year%400==0), else 28.
REQ-028 Without WATCH_LEAP_YEAR_EN: February length always 28; day_in=29 in February is invalid.

Structure
REQ-029 Shared package watch_pkg shall hold month-number constants, field widths (5/6/6/4/5/3), and MAX_HOUR/MAX_MIN/MAX_SEC.
REQ-030 Month-length lookup shall be sub-module watch_month_len (inputs month, year; output 5-bit length); it shall be instantiated twice (counting path, set validation).

Verification
REQ-031 TICK_DIV=1: set 2023-12-31 23:59:59 wday 6, one en cycle -> 2024-01-01 00:00:00, wday 0, day_roll and tick_sec one cycle.
REQ-032 Set 2024-02-28 23:59:59, one tick -> 2024-02-29 with macro, 2024-03-01 without; 2100-02-28 -> 2100-03-01 in both builds.
REQ-033 YEAR_W=12: set 4095-12-31 23:59:59, one tick -> 0001-01-01 00:00:00.
REQ-034 set_date 2023-04-31 -> set_err pulse, all outputs unchanged; set_time 24:00:00 -> set_err, time unchanged.
REQ-035 TICK_DIV=4: en high 12 cycles -> second +3, tick_sec every 4th cycle; en low 5 cycles mid-count -> no change, count resumes.
REQ-036 Assert rst after 2 of 4 prescaler cycles -> all reset values immediately; after release, first tick after exactly 4 enabled cycles.
